// File: rtl/kersram_w.sv
// Kernel SRAM write controller: streams bank-major kernel words into eight
// SRAM banks through one shared address/data bus with registered strobes.
module kersram_w #(
    parameter int ADDR_CNT_BITS = 10,
    parameter int DATA_BITS     = 64,
    parameter int KER_ST_LENGTH = 288
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_ker_write,
    output logic                     ker_write_busy,
    output logic                     ker_write_done,
    input  logic                     s_valid,
    input  logic [DATA_BITS-1:0]     s_data,
    output logic                     s_ready,
    output logic                     cen_kersw_0,
    output logic                     cen_kersw_1,
    output logic                     cen_kersw_2,
    output logic                     cen_kersw_3,
    output logic                     cen_kersw_4,
    output logic                     cen_kersw_5,
    output logic                     cen_kersw_6,
    output logic                     cen_kersw_7,
    output logic                     wen_kersw_0,
    output logic                     wen_kersw_1,
    output logic                     wen_kersw_2,
    output logic                     wen_kersw_3,
    output logic                     wen_kersw_4,
    output logic                     wen_kersw_5,
    output logic                     wen_kersw_6,
    output logic                     wen_kersw_7,
    output logic [ADDR_CNT_BITS-1:0] addr_kersw,
    output logic [DATA_BITS-1:0]     data_kersw
);

    // state | meaning
    // IDLE  | waiting for start_ker_write
    // WRITE | accepting stream beats, one bank strobe per accepted beat
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_CNT_BITS-1:0] WORD_LAST = ADDR_CNT_BITS'(KER_ST_LENGTH - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_CNT_BITS-1:0] word_cnt;
    logic [2:0]               bank_cnt;
    logic [7:0]               cen_q;
    logic [7:0]               wen_q;
    logic                     accept;
    logic                     word_wrap;
    logic                     last_beat;

    assign s_ready        = (state == WRITE);
    assign ker_write_busy = (state == WRITE);
    assign ker_write_done = (state == DONE);

    assign accept    = s_valid & s_ready;
    assign word_wrap = (word_cnt == WORD_LAST);
    assign last_beat = accept & word_wrap & (bank_cnt == 3'd7);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ker_write) state_nxt = WRITE;
            WRITE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters also wrap naturally after bank 7, so a restart only needs the clear on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            bank_cnt <= '0;
        end else if (state == IDLE && start_ker_write) begin
            word_cnt <= '0;
            bank_cnt <= '0;
        end else if (accept) begin
            if (word_wrap) begin
                word_cnt <= '0;
                bank_cnt <= bank_cnt + 3'd1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cen_q      <= '1;
            wen_q      <= '1;
            addr_kersw <= '0;
            data_kersw <= '0;
        end else begin
            cen_q <= '1;
            wen_q <= '1;
            if (accept) begin
                cen_q      <= ~(8'b1 << bank_cnt);
                wen_q      <= ~(8'b1 << bank_cnt);
                addr_kersw <= word_cnt;
                data_kersw <= s_data;
            end
        end
    end

    assign cen_kersw_0 = cen_q[0];
    assign cen_kersw_1 = cen_q[1];
    assign cen_kersw_2 = cen_q[2];
    assign cen_kersw_3 = cen_q[3];
    assign cen_kersw_4 = cen_q[4];
    assign cen_kersw_5 = cen_q[5];
    assign cen_kersw_6 = cen_q[6];
    assign cen_kersw_7 = cen_q[7];
    assign wen_kersw_0 = wen_q[0];
    assign wen_kersw_1 = wen_q[1];
    assign wen_kersw_2 = wen_q[2];
    assign wen_kersw_3 = wen_q[3];
    assign wen_kersw_4 = wen_q[4];
    assign wen_kersw_5 = wen_q[5];
    assign wen_kersw_6 = wen_q[6];
    assign wen_kersw_7 = wen_q[7];

endmodule

// File: tb/tb_kersram_w.sv
// Scoreboard bench for kersram_w: the driver queues the expected strobe for
// every beat it issues, a negedge monitor pops and compares every strobe seen.
module tb_kersram_w;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        start;
    logic        s_valid;
    logic [63:0] s_data;

    logic        start_a, start_b, s_valid_a, s_valid_b;
    logic        busy_a, busy_b, done_a, done_b, s_ready_a, s_ready_b;
    wire  [7:0]  cen_a, cen_b, wen_a, wen_b;
    logic [9:0]  addr_a, addr_b;
    logic [63:0] data_a, data_b;

    logic [7:0]  cen_m, wen_m;
    logic [9:0]  addr_m;
    logic [63:0] data_m;
    logic        busy_m, done_m, s_ready_m;

    assign start_a   = sel ? 1'b0 : start;
    assign start_b   = sel ? start : 1'b0;
    assign s_valid_a = sel ? 1'b0 : s_valid;
    assign s_valid_b = sel ? s_valid : 1'b0;
    assign cen_m     = sel ? cen_b : cen_a;
    assign wen_m     = sel ? wen_b : wen_a;
    assign addr_m    = sel ? addr_b : addr_a;
    assign data_m    = sel ? data_b : data_a;
    assign busy_m    = sel ? busy_b : busy_a;
    assign done_m    = sel ? done_b : done_a;
    assign s_ready_m = sel ? s_ready_b : s_ready_a;

    kersram_w #(.ADDR_CNT_BITS(10), .DATA_BITS(64), .KER_ST_LENGTH(288)) dut_a (
        .clk(clk), .reset(reset), .start_ker_write(start_a),
        .ker_write_busy(busy_a), .ker_write_done(done_a),
        .s_valid(s_valid_a), .s_data(s_data), .s_ready(s_ready_a),
        .cen_kersw_0(cen_a[0]), .cen_kersw_1(cen_a[1]), .cen_kersw_2(cen_a[2]), .cen_kersw_3(cen_a[3]),
        .cen_kersw_4(cen_a[4]), .cen_kersw_5(cen_a[5]), .cen_kersw_6(cen_a[6]), .cen_kersw_7(cen_a[7]),
        .wen_kersw_0(wen_a[0]), .wen_kersw_1(wen_a[1]), .wen_kersw_2(wen_a[2]), .wen_kersw_3(wen_a[3]),
        .wen_kersw_4(wen_a[4]), .wen_kersw_5(wen_a[5]), .wen_kersw_6(wen_a[6]), .wen_kersw_7(wen_a[7]),
        .addr_kersw(addr_a), .data_kersw(data_a)
    );

    kersram_w #(.ADDR_CNT_BITS(10), .DATA_BITS(64), .KER_ST_LENGTH(4)) dut_b (
        .clk(clk), .reset(reset), .start_ker_write(start_b),
        .ker_write_busy(busy_b), .ker_write_done(done_b),
        .s_valid(s_valid_b), .s_data(s_data), .s_ready(s_ready_b),
        .cen_kersw_0(cen_b[0]), .cen_kersw_1(cen_b[1]), .cen_kersw_2(cen_b[2]), .cen_kersw_3(cen_b[3]),
        .cen_kersw_4(cen_b[4]), .cen_kersw_5(cen_b[5]), .cen_kersw_6(cen_b[6]), .cen_kersw_7(cen_b[7]),
        .wen_kersw_0(wen_b[0]), .wen_kersw_1(wen_b[1]), .wen_kersw_2(wen_b[2]), .wen_kersw_3(wen_b[3]),
        .wen_kersw_4(wen_b[4]), .wen_kersw_5(wen_b[5]), .wen_kersw_6(wen_b[6]), .wen_kersw_7(wen_b[7]),
        .addr_kersw(addr_b), .data_kersw(data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          bank;
        int          addr;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   nstrobe = 0;
    int   ndone   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the queue in cycle, bank, addr and data.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] ev;
        if (cen_m != 8'hFF || wen_m != 8'hFF) begin
            nstrobe++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected cyc=%0d: got cen=%b wen=%b addr=%0d, want no strobe",
                         cyc, cen_m, wen_m, addr_m);
            end else begin
                e  = exp_q.pop_front();
                ev = ~(8'b1 << e.bank);
                if (cyc != e.cyc || cen_m != ev || wen_m != ev ||
                    addr_m != 10'(e.addr) || data_m != e.data) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d: got cen=%b wen=%b addr=%0d data=%0d, want cyc=%0d cen=%b addr=%0d data=%0d",
                             cyc, cen_m, wen_m, addr_m, data_m, e.cyc, ev, e.addr, e.data);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe_missing cyc=%0d: got no strobe, want bank=%0d addr=%0d", cyc, e.bank, e.addr);
        end
        if (done_m) begin
            ndone++;
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d: got done=1, want 0", cyc);
            end else begin
                int dc;
                dc = done_q.pop_front();
                if (dc != cyc || busy_m != 1'b0) begin
                    errors++;
                    $display("FAIL done cyc=%0d busy=%0d: want cyc=%0d busy=0", cyc, busy_m, dc);
                end
            end
        end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
            int dc;
            dc = done_q.pop_front();
            checks++;
            errors++;
            $display("FAIL done_missing cyc=%0d: got done=0, want done at cyc=%0d", cyc, dc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (cen_m != 8'hFF || wen_m != 8'hFF || busy_m != 1'b0 || s_ready_m != 1'b0 || done_m != 1'b0) begin
            errors++;
            $display("FAIL %s: got cen=%b wen=%b busy=%0d ready=%0d done=%0d, want cen/wen=ff busy/ready/done=0",
                     name, cen_m, wen_m, busy_m, s_ready_m, done_m);
        end
    endtask

    // Entered #1 after an edge; returns in the DONE cycle (or right after an abort).
    task automatic load(input int len, input bit rnd, input int poke_at, input int abort_at);
        int   k;
        logic v;
        start = 1'b1;
        check_int("ready_before_start", int'(s_ready_m), 0);
        step();
        start = 1'b0;
        k = 0;
        while (k < 8 * len) begin
            v       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = 64'(k);
            start   = (k == poke_at);
            check_int("ready_in_write", int'(s_ready_m), 1);
            if (v) begin
                exp_q.push_back('{cyc + 1, k / len, k % len, 64'(k)});
                if (k == 8 * len - 1) done_q.push_back(cyc + 1);
            end
            if (v && k == abort_at) begin
                #5;
                reset = 1'b0;
                #1;
                check_idle_outputs("async_reset_abort");
                exp_q.delete();
                s_valid = 1'b0;
                start   = 1'b0;
                return;
            end
            if (v) k++;
            step();
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) step();
        check_idle_outputs("reset_outputs");
        check_int("reset_addr", int'(addr_m), 0);
        checks++;
        if (data_m != 64'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d, want 0", data_m);
        end
        reset = 1'b1;
        step();
        step();

        // Full load, start poked at beat 100 and again during DONE.
        nstrobe = 0; ndone = 0;
        load(288, 1'b0, 100, -1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle_outputs("start_in_done_ignored");
        step();
        check_idle_outputs("idle_after_done");
        check_int("full_strobe_count", nstrobe, 2304);
        check_int("full_done_count", ndone, 1);

        // 50% valid duty.
        nstrobe = 0; ndone = 0;
        load(288, 1'b1, -1, -1);
        step();
        step();
        check_int("rand_strobe_count", nstrobe, 2304);
        check_int("rand_done_count", ndone, 1);

        // Asynchronous reset at beat 1000, then a fresh load from bank 0.
        load(288, 1'b0, -1, 1000);
        repeat (3) step();
        check_idle_outputs("held_in_reset");
        reset = 1'b1;
        step();
        nstrobe = 0; ndone = 0;
        load(288, 1'b0, -1, -1);
        step();
        step();
        check_int("restart_strobe_count", nstrobe, 2304);
        check_int("restart_done_count", ndone, 1);

        // Short instance: back-to-back loads, second start in the cycle after done.
        sel = 1'b1;
        step();
        nstrobe = 0; ndone = 0;
        load(4, 1'b0, -1, -1);
        step();
        check_int("b2b_first_strobes", nstrobe, 32);
        check_int("b2b_first_done", ndone, 1);
        nstrobe = 0; ndone = 0;
        load(4, 1'b0, -1, -1);
        step();
        step();
        check_int("b2b_second_strobes", nstrobe, 32);
        check_int("b2b_second_done", ndone, 1);

        repeat (3) step();
        check_int("exp_queue_empty", exp_q.size(), 0);
        check_int("done_queue_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
